// File: rtl/serial_subtractor_if.sv
// Start/operand request and result bus of the bit-serial subtractor.
// The requester drives start/a/b; the subtractor returns busy/done/diff/borrow.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// with the final borrow reported alongside a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             bi;
    logic [CNT_W-1:0] cnt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    // Full-subtractor step on the current LSBs of the operand shift registers.
    logic             x;
    logic             y;
    logic             d;
    logic             bo;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        x        = sa[0];
        y        = sb[0];
        d        = x ^ y ^ bi;
        bo       = (~x & y) | (~(x ^ y) & bi);
        acc_next = {d, acc[WIDTH-1:1]};
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values; the datapath registers are reset too, so no X ever leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            acc      <= '0;
            bi       <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        acc    <= '0;
                        bi     <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    bi  <= bo;
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    // Last bit: publish the result including this cycle's d/bo.
                    if (cnt == LAST_BIT) begin
                        diff_q   <= acc_next;
                        borrow_q <= bo;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    serial_subtractor_if #(.WIDTH(8))  bus8 ();
    serial_subtractor_if #(.WIDTH(16)) bus16 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for done on the selected instance (0: WIDTH=8, 1: WIDTH=16).
    // cyc counts edges since the start edge; busy must stay high until done.
    task automatic wait_done(input int w, output int cyc, output bit busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        while (((w == 0) ? bus8.done : bus16.done) !== 1'b1 && cyc < 64) begin
            if (((w == 0) ? bus8.busy : bus16.busy) !== 1'b1) busy_ok = 1'b0;
            step();
            cyc++;
        end
    endtask

    task automatic run_op8(input logic [7:0] ai, input logic [7:0] bi_, input logic [7:0] ed,
                           input logic eb, input string tag);
        int cyc;
        bit busy_ok;
        bus8.a     = ai;
        bus8.b     = bi_;
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        wait_done(0, cyc, busy_ok);
        check({tag, "_latency"}, 64'(cyc), 64'd8);
        check({tag, "_busy_during_run"}, 64'(busy_ok), 64'd1);
        check({tag, "_diff"}, 64'(bus8.diff), 64'(ed));
        check({tag, "_borrow"}, 64'(bus8.borrow), 64'(eb));
        check({tag, "_busy_low_at_done"}, 64'(bus8.busy), 64'd0);
        step();
        check({tag, "_done_one_cycle"}, 64'(bus8.done), 64'd0);
    endtask

    initial begin
        vec_t vecs[9];
        int cyc;
        bit busy_ok;
        bit saw_done;
        logic [7:0]  ra8, rb8;
        logic [15:0] ra16, rb16;
        bit rand_ok8, rand_ok16, space_ok8, space_ok16;

        vecs[0] = '{a: 8'h5A, b: 8'h23, diff: 8'h37, borrow: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1};
        vecs[2] = '{a: 8'hA5, b: 8'hA5, diff: 8'h00, borrow: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'h00, diff: 8'hFF, borrow: 1'b0};
        vecs[4] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, borrow: 1'b1};
        vecs[5] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0};
        vecs[6] = '{a: 8'h01, b: 8'hFF, diff: 8'h02, borrow: 1'b1};
        vecs[7] = '{a: 8'h00, b: 8'h80, diff: 8'h80, borrow: 1'b1};
        vecs[8] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, borrow: 1'b0};

        bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;

        // Reset state
        #2;
        check("reset_busy", 64'(bus8.busy), 64'd0);
        check("reset_done", 64'(bus8.done), 64'd0);
        check("reset_diff", 64'(bus8.diff), 64'd0);
        check("reset_borrow", 64'(bus8.borrow), 64'd0);
        step();
        #2 rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++)
            run_op8(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, $sformatf("vec%0d", i));

        // Operands change and start stays high during busy; the done-cycle start chains a second op.
        bus8.a = 8'h10; bus8.b = 8'h20; bus8.start = 1'b1;
        step();
        bus8.a = 8'h77; bus8.b = 8'h11;
        wait_done(0, cyc, busy_ok);
        check("hold_first_latency", 64'(cyc), 64'd8);
        check("hold_first_busy", 64'(busy_ok), 64'd1);
        check("hold_first_diff", 64'(bus8.diff), 64'hF0);
        check("hold_first_borrow", 64'(bus8.borrow), 64'd1);
        step();
        bus8.start = 1'b0;
        check("hold_chain_busy", 64'(bus8.busy), 64'd1);
        check("hold_chain_done_low", 64'(bus8.done), 64'd0);
        check("hold_prev_diff_kept", 64'(bus8.diff), 64'hF0);
        wait_done(0, cyc, busy_ok);
        check("hold_second_latency", 64'(cyc), 64'd8);
        check("hold_second_diff", 64'(bus8.diff), 64'h66);
        check("hold_second_borrow", 64'(bus8.borrow), 64'd0);
        step();

        // Asynchronous reset mid-operation discards it.
        run_op8(8'h01, 8'hFF, 8'h02, 1'b1, "pre_reset");
        bus8.a = 8'h80; bus8.b = 8'h01; bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(bus8.busy), 64'd0);
        check("async_rst_done", 64'(bus8.done), 64'd0);
        check("async_rst_diff", 64'(bus8.diff), 64'd0);
        check("async_rst_borrow", 64'(bus8.borrow), 64'd0);
        step(); step();
        #2 rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) saw_done = 1'b1;
        end
        check("no_done_after_reset", 64'(saw_done), 64'd0);
        run_op8(8'h03, 8'h05, 8'hFE, 1'b1, "post_reset");

        // Randomised operands with start held high so operations chain back to back.
        rand_ok8 = 1'b1; space_ok8 = 1'b1;
        bus8.start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom);
            bus8.a = ra8; bus8.b = rb8;
            step();
            wait_done(0, cyc, busy_ok);
            if (cyc < 8 || cyc >= 64 || !busy_ok) space_ok8 = 1'b0;
            if ({bus8.borrow, bus8.diff} !== ({1'b0, ra8} - {1'b0, rb8})) begin
                if (rand_ok8)
                    $display("FAIL rand8_result: a=0x%0h b=0x%0h got {%0b,0x%0h}", ra8, rb8,
                             bus8.borrow, bus8.diff);
                rand_ok8 = 1'b0;
            end
        end
        bus8.start = 1'b0;
        step();
        check("rand8_results", 64'(rand_ok8), 64'd1);
        check("rand8_spacing", 64'(space_ok8), 64'd1);

        rand_ok16 = 1'b1; space_ok16 = 1'b1;
        bus16.start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra16 = 16'($urandom); rb16 = 16'($urandom);
            if (i == 0) begin ra16 = 16'h0000; rb16 = 16'hFFFF; end
            bus16.a = ra16; bus16.b = rb16;
            step();
            wait_done(1, cyc, busy_ok);
            if (cyc < 16 || cyc >= 64 || !busy_ok) space_ok16 = 1'b0;
            if ({bus16.borrow, bus16.diff} !== ({1'b0, ra16} - {1'b0, rb16})) begin
                if (rand_ok16)
                    $display("FAIL rand16_result: a=0x%0h b=0x%0h got {%0b,0x%0h}", ra16, rb16,
                             bus16.borrow, bus16.diff);
                rand_ok16 = 1'b0;
            end
        end
        bus16.start = 1'b0;
        step();
        check("rand16_results", 64'(rand_ok16), 64'd1);
        check("rand16_spacing", 64'(space_ok16), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
